// File: rtl/step_dir_decoder.sv
`default_nettype none
// +------------------------------------------------------------------+
// | step_dir_decoder: step/dir pulse decoder with position, period,   |
// | pulse-width measurement and glitch rejection.      Rev 1.0        |
// +------------------------------------------------------------------+
module step_dir_decoder #(
  parameter int WIDTH     = 16,
  parameter int MIN_WIDTH = 4,
  parameter int TIMEOUT   = 'hFFFF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic             clr,
  input  logic             drv_pulse,
  input  logic             drv_dir,
  input  logic             pulse_invert,
  output logic             step_valid,
  output logic [WIDTH-1:0] position,
  output logic [WIDTH-1:0] step_count,
  output logic [WIDTH-1:0] period,
  output logic [WIDTH-1:0] pulse_width,
  output logic             stalled,
  output logic             glitch
);

  localparam logic [WIDTH-1:0] c_min_width = WIDTH'(MIN_WIDTH);
  localparam logic [WIDTH-1:0] c_timeout   = WIDTH'(TIMEOUT);
  localparam logic [WIDTH-1:0] c_one       = WIDTH'(1);
  localparam logic [WIDTH-1:0] c_max       = '1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HIGH = 2'd1,
    ST_LOW  = 2'd2
  } state_t;

  logic pulse_s1_q, pulse_s1_d, pulse_s2_q, pulse_s2_d;
  logic dir_s1_q, dir_s1_d, dir_s2_q, dir_s2_d;
  logic p, p_q, p_d;
  logic rise_q, rise_d, fall_q, fall_d;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] width_q, width_d, gap_q, gap_d;
  logic [WIDTH-1:0] width_inc, gap_inc;
  logic             dir_q, dir_d;
  logic             armed_q, armed_d;

  logic             step_valid_q, step_valid_d;
  logic [WIDTH-1:0] position_q, position_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic [WIDTH-1:0] period_q, period_d;
  logic [WIDTH-1:0] pw_q, pw_d;
  logic             glitch_q, glitch_d;

  assign p         = pulse_s2_q ^ pulse_invert;
  assign width_inc = (width_q == c_max) ? width_q : width_q + c_one;
  assign gap_inc   = (gap_q == c_max) ? gap_q : gap_q + c_one;

  always_comb begin
    pulse_s1_d = drv_pulse;
    pulse_s2_d = pulse_s1_q;
    dir_s1_d   = drv_dir;
    dir_s2_d   = dir_s1_q;
    p_d        = p;
    rise_d     = p & ~p_q;
    fall_d     = ~p & p_q;
  end

  always_comb begin
    state_d      = state_q;
    width_d      = width_q;
    gap_d        = gap_q;
    dir_d        = dir_q;
    armed_d      = armed_q;
    step_valid_d = 1'b0;
    position_d   = position_q;
    count_d      = count_q;
    period_d     = period_q;
    pw_d         = pw_q;
    glitch_d     = glitch_q;

    if (!enable) begin
      state_d = ST_IDLE;
      width_d = '0;
      gap_d   = '0;
      armed_d = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          armed_d = 1'b0;
          if (rise_q) begin
            state_d = ST_HIGH;
            width_d = c_one;
            gap_d   = c_one;
            dir_d   = dir_s2_q;
          end
        end
        ST_HIGH: begin
          gap_d = gap_inc;
          if (fall_q) begin
            if (width_q >= c_min_width) begin
              step_valid_d = 1'b1;
              pw_d         = width_q;
              count_d      = count_q + c_one;
              position_d   = dir_q ? position_q + c_one : position_q - c_one;
              armed_d      = 1'b1;
              state_d      = ST_LOW;
            end else begin
              glitch_d = 1'b1;
              state_d  = armed_q ? ST_LOW : ST_IDLE;
            end
          end else begin
            width_d = width_inc;
          end
          if (gap_q >= c_timeout) begin
            state_d  = ST_IDLE;
            period_d = '0;
            armed_d  = 1'b0;
          end
        end
        ST_LOW: begin
          // A rise landing exactly on the timeout cycle still counts as a step edge.
          if (rise_q) begin
            state_d = ST_HIGH;
            if (armed_q) period_d = gap_q;
            gap_d   = c_one;
            width_d = c_one;
            dir_d   = dir_s2_q;
          end else if (gap_q >= c_timeout) begin
            state_d  = ST_IDLE;
            period_d = '0;
            armed_d  = 1'b0;
          end else begin
            gap_d = gap_inc;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end

    if (clr) begin
      position_d = '0;
      count_d    = '0;
      glitch_d   = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pulse_s1_q   <= 1'b0;
      pulse_s2_q   <= 1'b0;
      dir_s1_q     <= 1'b0;
      dir_s2_q     <= 1'b0;
      // Edge register starts at the inactive level so no edge appears on release.
      p_q          <= pulse_invert;
      rise_q       <= 1'b0;
      fall_q       <= 1'b0;
      state_q      <= ST_IDLE;
      width_q      <= '0;
      gap_q        <= '0;
      dir_q        <= 1'b0;
      armed_q      <= 1'b0;
      step_valid_q <= 1'b0;
      position_q   <= '0;
      count_q      <= '0;
      period_q     <= '0;
      pw_q         <= '0;
      glitch_q     <= 1'b0;
    end else begin
      pulse_s1_q   <= pulse_s1_d;
      pulse_s2_q   <= pulse_s2_d;
      dir_s1_q     <= dir_s1_d;
      dir_s2_q     <= dir_s2_d;
      p_q          <= p_d;
      rise_q       <= rise_d;
      fall_q       <= fall_d;
      state_q      <= state_d;
      width_q      <= width_d;
      gap_q        <= gap_d;
      dir_q        <= dir_d;
      armed_q      <= armed_d;
      step_valid_q <= step_valid_d;
      position_q   <= position_d;
      count_q      <= count_d;
      period_q     <= period_d;
      pw_q         <= pw_d;
      glitch_q     <= glitch_d;
    end
  end

  assign step_valid  = step_valid_q;
  assign position    = position_q;
  assign step_count  = count_q;
  assign period      = period_q;
  assign pulse_width = pw_q;
  assign stalled     = (state_q == ST_IDLE);
  assign glitch      = glitch_q;

endmodule
`default_nettype wire
